// File: rtl/status_reg_if.sv
// Flag/status bus between the CPU core, the ALU and the status register.
// The status register sits on the slave side; the core/ALU drive the master side.
interface status_reg_if;
  logic [3:0] upd_mask;
  logic       alu_n;
  logic       alu_z;
  logic       alu_v;
  logic       alu_c;
  logic [2:0] flag_op;
  logic       p_load;
  logic [7:0] p_din;
  logic       irq_set;
  logic       push_brk;
  logic [2:0] br_cond;
  logic [7:0] p;
  logic [7:0] p_push;
  logic       alu_ci;
  logic       dec;
  logic       br_taken;

  modport slave (
    input  upd_mask, alu_n, alu_z, alu_v, alu_c, flag_op, p_load, p_din,
           irq_set, push_brk, br_cond,
    output p, p_push, alu_ci, dec, br_taken
  );

  modport master (
    output upd_mask, alu_n, alu_z, alu_v, alu_c, flag_op, p_load, p_din,
           irq_set, push_brk, br_cond,
    input  p, p_push, alu_ci, dec, br_taken
  );
endinterface

// File: rtl/status_reg.sv
// 6502 status register P with pipelined ALU flag commit, operand forwarding
// for carry-in and branch evaluation, and the PHP/BRK push byte.
module status_reg #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic         clk,
  input  logic         rst,
  status_reg_if.slave  bus
);

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLD  = 3'd5,
    FOP_SED  = 3'd6,
    FOP_CLV  = 3'd7
  } flag_op_e;

  // ALU-sourced flags are kept as a vector ordered like upd_mask: {N, Z, V, C}
  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FV = 1;
  localparam int FC = 0;

  logic [3:0] nzvc_reg;
  logic [3:0] nzvc_next;
  logic       d_reg;
  logic       d_next;
  logic       i_reg;
  logic       i_next;
  logic [3:0] pend_reg;

  logic [3:0] alu_vec;
  logic [3:0] fwd;
  logic [7:0] pulled_p;
  logic       br_flag;

  assign alu_vec = {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};

  // Bits 5:4 of a pulled byte have no storage in P.
  assign pulled_p = bus.p_din & 8'hCF;

  // A pending commit is the freshest value of a flag, so it wins over the register.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
    assign fwd[gi] = pend_reg[gi] ? alu_vec[gi] : nzvc_reg[gi];
  end

  always_comb begin
    nzvc_next = fwd;
    d_next    = d_reg;
    i_next    = i_reg;

    case (flag_op_e'(bus.flag_op))
      FOP_CLC: nzvc_next[FC] = 1'b0;
      FOP_SEC: nzvc_next[FC] = 1'b1;
      FOP_CLV: nzvc_next[FV] = 1'b0;
      FOP_CLI: i_next        = 1'b0;
      FOP_SEI: i_next        = 1'b1;
      FOP_CLD: d_next        = 1'b0;
      FOP_SED: d_next        = 1'b1;
      default: ;
    endcase

    if (bus.irq_set) begin
      i_next = 1'b1;
    end

    if (bus.p_load) begin
      nzvc_next = {pulled_p[7], pulled_p[1], pulled_p[6], pulled_p[0]};
      d_next    = pulled_p[3];
      i_next    = pulled_p[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nzvc_reg <= {RESET_P[7], RESET_P[1], RESET_P[6], RESET_P[0]};
      d_reg    <= RESET_P[3];
      i_reg    <= RESET_P[2];
      pend_reg <= 4'b0000;
    end else begin
      nzvc_reg <= nzvc_next;
      d_reg    <= d_next;
      i_reg    <= i_next;
      pend_reg <= bus.upd_mask;
    end
  end

  always_comb begin
    case (bus.br_cond[2:1])
      2'b00:   br_flag = fwd[FN];
      2'b01:   br_flag = fwd[FV];
      2'b10:   br_flag = fwd[FC];
      default: br_flag = fwd[FZ];
    endcase
  end

  assign bus.p        = {nzvc_reg[FN], nzvc_reg[FV], 1'b1, 1'b0,
                         d_reg, i_reg, nzvc_reg[FZ], nzvc_reg[FC]};
  assign bus.p_push   = {nzvc_reg[FN], nzvc_reg[FV], 1'b1, bus.push_brk,
                         d_reg, i_reg, nzvc_reg[FZ], nzvc_reg[FC]};
  assign bus.alu_ci   = fwd[FC];
  assign bus.dec      = d_reg;
  assign bus.br_taken = (br_flag == bus.br_cond[0]);

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed scenarios followed by random
// cycles, all compared against a byte-level model of P.
module tb_status_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  status_reg_if bus ();

  status_reg #(.RESET_P(8'h24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc    = 0;

  // Model: P as a byte (bit5=1, bit4=0) plus the mask issued last cycle.
  logic [7:0] m_p    = 8'h24;
  logic [3:0] m_pend = 4'h0;
  bit         m_valid = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, got, exp, n_cyc);
  endtask

  // P as it would look if last cycle's pending ALU flags were already written.
  function automatic logic [7:0] fresh_p();
    logic [7:0] f;
    f = m_p;
    if (m_pend[3]) f[7] = bus.alu_n;
    if (m_pend[2]) f[1] = bus.alu_z;
    if (m_pend[1]) f[6] = bus.alu_v;
    if (m_pend[0]) f[0] = bus.alu_c;
    return f;
  endfunction

  task automatic check_outputs();
    logic [7:0] f;
    int pos;
    f = fresh_p();
    case (bus.br_cond[2:1])
      2'd0:    pos = 7;
      2'd1:    pos = 6;
      2'd2:    pos = 0;
      default: pos = 1;
    endcase
    check("p",        bus.p,                m_p);
    check("p_push",   bus.p_push,           m_p | (bus.push_brk ? 8'h10 : 8'h00));
    check("alu_ci",   {7'd0, bus.alu_ci},   {7'd0, f[0]});
    check("dec",      {7'd0, bus.dec},      {7'd0, m_p[3]});
    check("br_taken", {7'd0, bus.br_taken}, {7'd0, (f[pos] == bus.br_cond[0])});
  endtask

  task automatic drive(input logic r, input logic [3:0] um, input logic [3:0] alu,
                       input logic [2:0] fo, input logic pl, input logic [7:0] pd,
                       input logic irq, input logic pb, input logic [2:0] bc);
    @(negedge clk);
    rst          = r;
    bus.upd_mask = um;
    {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = alu;
    bus.flag_op  = fo;
    bus.p_load   = pl;
    bus.p_din    = pd;
    bus.irq_set  = irq;
    bus.push_brk = pb;
    bus.br_cond  = bc;
    #1;
    if (m_valid) check_outputs();
  endtask

  // Advance one edge and apply the flag rules, lowest priority first.
  task automatic edge_step();
    logic [7:0] np;
    @(posedge clk);
    $display("cyc %0d rst=%b um=%h alu=%b%b%b%b fop=%0d pl=%b din=%02h irq=%b -> p_before=%02h",
             n_cyc, rst, bus.upd_mask, bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c,
             bus.flag_op, bus.p_load, bus.p_din, bus.irq_set, bus.p);
    if (rst) begin
      m_p     = 8'h24;
      m_pend  = 4'h0;
      m_valid = 1'b1;
    end else begin
      np = fresh_p();
      case (bus.flag_op)
        3'd1: np[0] = 1'b0;
        3'd2: np[0] = 1'b1;
        3'd3: np[2] = 1'b0;
        3'd4: np[2] = 1'b1;
        3'd5: np[3] = 1'b0;
        3'd6: np[3] = 1'b1;
        3'd7: np[6] = 1'b0;
        default: ;
      endcase
      if (bus.irq_set) np[2] = 1'b1;
      if (bus.p_load)  np = (bus.p_din & 8'hCF) | 8'h20;
      m_p    = np;
      m_pend = bus.upd_mask;
    end
    n_cyc++;
    #1;
  endtask

  task automatic cyc(input logic r, input logic [3:0] um, input logic [3:0] alu,
                     input logic [2:0] fo, input logic pl, input logic [7:0] pd,
                     input logic irq, input logic pb, input logic [2:0] bc);
    drive(r, um, alu, fo, pl, pd, irq, pb, bc);
    edge_step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.upd_mask = 4'h0;
    {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c} = 4'h0;
    bus.flag_op  = 3'd0;
    bus.p_load   = 1'b0;
    bus.p_din    = 8'h00;
    bus.irq_set  = 1'b0;
    bus.push_brk = 1'b0;
    bus.br_cond  = 3'd0;

    cyc(1, 4'h0, 4'h0, 0, 0, 8'h00, 0, 0, 3'd0);
    cyc(1, 4'h0, 4'h0, 0, 0, 8'h00, 0, 0, 3'd0);

    // Reset discards an in-flight update
    cyc(0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 3'd0);
    cyc(1, 4'h0, 4'hF, 0, 0, 8'hFF, 0, 0, 3'd0);
    check("rst_p", bus.p, 8'h24);
    check("rst_alu_ci", {7'd0, bus.alu_ci}, 8'h00);
    cyc(0, 4'h0, 4'hF, 0, 0, 8'h00, 0, 0, 3'd0);
    check("post_rst_p", bus.p, 8'h24);

    // ALU carry commit with forwarding
    cyc(0, 4'b0001, 4'b1110, 0, 0, 8'h00, 0, 0, 3'd0);
    drive(0, 4'h0, 4'b0001, 0, 0, 8'h00, 0, 0, 3'd0);
    check("fwd_alu_ci", {7'd0, bus.alu_ci}, 8'h01);
    edge_step();
    check("commit_p", bus.p, 8'h25);

    // CLV overrides a pending V commit
    cyc(0, 4'b0010, 4'h0, 0, 0, 8'h00, 0, 0, 3'd0);
    cyc(0, 4'h0, 4'b0010, 3'd7, 0, 8'h00, 0, 0, 3'd0);
    check("clv_ovr_p", bus.p, 8'h25);

    // SEC alongside a pending Z commit
    cyc(0, 4'b0100, 4'h0, 3'd1, 0, 8'h00, 0, 0, 3'd0);
    cyc(0, 4'h0, 4'b0100, 3'd2, 0, 8'h00, 0, 0, 3'd0);
    check("sec_z_p", bus.p, 8'h27);

    // PLP beats flag_op and pending commits
    cyc(0, 4'hF, 4'h0, 0, 0, 8'h00, 0, 0, 3'd0);
    cyc(0, 4'h0, 4'h0, 3'd1, 1, 8'hFF, 0, 0, 3'd0);
    check("plp_p", bus.p, 8'hEF);

    // Interrupt entry beats CLI
    cyc(0, 4'h0, 4'h0, 0, 1, 8'h00, 0, 0, 3'd0);
    drive(0, 4'h0, 4'h0, 3'd3, 0, 8'h00, 1, 1, 3'd0);
    check("irq_p_push", bus.p_push, 8'h30);
    edge_step();
    check("irq_p", bus.p, 8'h24);

    // BEQ / BNE on a forwarded Z
    cyc(0, 4'b0100, 4'h0, 0, 0, 8'h00, 0, 0, 3'd0);
    drive(0, 4'h0, 4'b0100, 0, 0, 8'h00, 0, 0, 3'b111);
    check("beq_taken", {7'd0, bus.br_taken}, 8'h01);
    bus.br_cond = 3'b110;
    #1;
    check("bne_taken", {7'd0, bus.br_taken}, 8'h00);
    edge_step();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 31) == 0),
          4'($urandom), 4'($urandom), 3'($urandom),
          ($urandom_range(0, 7) == 0), 8'($urandom),
          ($urandom_range(0, 7) == 0), 1'($urandom), 3'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/status_reg.md
Name: status_reg

Overview:
- Holds the 6502 processor status register P (N V - B D I Z C) and is the consumer end of the ALU flag interface.
- Takes the ALU's registered N/Z/V/C outputs one cycle after the ALU op is issued and merges them into P under a per-instruction update mask.
- Applies explicit flag instructions, PLP loads and interrupt entry to P.
- Feeds carry back to the ALU, produces the byte pushed by PHP/BRK/IRQ, and evaluates branch conditions.

Parameters:
- RESET_P, 8'h24, value of P after reset (I=1, bit5=1, all others 0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- upd_mask  in  4  {N,Z,V,C} update request, issued in the same cycle as the ALU op
- alu_n, alu_z, alu_v, alu_c  in  1 each  ALU flag outputs, valid one cycle after the op
- flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLD, 6 SED, 7 CLV
- p_load  in  1  load P from p_din (PLP/RTI)
- p_din  in  8  pulled status byte
- irq_set  in  1  interrupt/BRK entry; sets I
- push_brk  in  1  B-bit value for p_push
- br_cond  in  3  branch opcode bits [7:5]: [2:1] selects flag (00 N, 01 V, 10 C, 11 Z), [0] is the compare value
- p  out  8  current P; bit5=1, bit4=0
- p_push  out  8  P for stack push; bit5=1, bit4=push_brk
- alu_ci  out  1  carry-in to the ALU (forwarded)
- dec  out  1  D flag for decimal-mode logic
- br_taken  out  1  selected forwarded flag equals br_cond[0]

Behaviour:
- State:
  - flag registers N, V, D, I, Z, C
  - pend[3:0]: the upd_mask captured each cycle (pend <= upd_mask)
- Reset (rst=1 at clk edge):
  - P <= RESET_P, pend <= 0; any in-flight update is discarded.
  - Outputs after reset: p=8'h24, p_push=8'h24|(push_brk<<4), dec=0, alu_ci=0.
- Pipelined ALU update: at the edge ending cycle t+1, each flag x with pend[x]=1 is written from the alu_* value present in cycle t+1. ALU-sourced latency is therefore 2 edges from upd_mask to a visible p.
- Forwarding: combinational. fwd_x = pend[x] ? alu_x : reg_x for N, Z, V, C.
  - alu_ci = fwd_C
  - br_taken uses fwd flags, so branches and ADC/SBC chains see a result from the previous op without a stall.
- flag_op: applied at the next edge, same cycle as any pend commit. On the same bit, flag_op overrides pend (e.g. CLV with pend[V]=1 leaves V=0).
- irq_set: I <= 1 at the next edge. It overrides CLI issued in the same cycle.
- p_load: precedence over everything except rst. All six flags <= p_din bits {7,6,3,2,1,0}; p_din bits 5:4 are ignored. Pending ALU commits and flag_op in that cycle are dropped, but pend is still reloaded from upd_mask.
- Priority, per bit: rst > p_load > irq_set (I only) > flag_op > pend commit > hold.
- Back-to-back: upd_mask asserted on consecutive cycles is legal. Each cycle's commit uses that cycle's alu_* values.
- p and p_push are combinational from the registers only; they are not forwarded.
- D affects only the dec output; no arithmetic is done here.

Test Plan:
- Reset: assert rst with pend=4'hF and garbage alu_* -> p=8'h24, alu_ci=0. The cycle after release with upd_mask=0 -> p still 8'h24.
- ALU commit and forward: upd_mask=4'b0001 at t, alu_c=1 at t+1 -> alu_ci=1 during t+1; p[0]=1 after the t+1 edge. Flags N/Z/V unchanged.
- Override: pend[V]=1 with alu_v=1 and flag_op=CLV in the same cycle -> V=0. Separately, SEC with pend[Z] set -> C=1 and Z=alu_z.
- PLP precedence: p_load=1, p_din=8'hFF, flag_op=CLC, pend=4'hF with alu_* all 0 -> p=8'hEF.
- Interrupt: irq_set=1, flag_op=CLI, push_brk=1, starting from p=8'h20 -> p_push=8'h30 in that cycle; p=8'h24 after the edge.
- Branch: pend[Z]=1 with alu_z=1, Z register 0, br_cond=3'b111 (BEQ) -> br_taken=1. br_cond=3'b110 -> br_taken=0.
